// File: rtl/alu_pipe_cc.sv
// alu_pipe_cc: two-stage valid/ready Y86-64 ALU with a ZF/SF/OF condition-code register; define ALU_SATURATE_EN to saturate add/sub overflow
module alu_pipe_cc #(
    parameter int WIDTH = 64,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ans,
    output logic             out_overflow,
    output logic             out_illegal,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);
    logic             s1_valid_q, s1_set_cc_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [OP_W-1:0]  s1_op_q;
    logic             s2_valid_q, s2_ovf_q, s2_ill_q, s2_set_cc_q, s2_zf_q, s2_sf_q;
    logic [WIDTH-1:0] s2_ans_q;
    logic             cc_zf_q, cc_sf_q, cc_of_q;
    logic             adv1, adv2;
    logic [WIDTH-1:0] sum, dif, raw, s2_ans_d;
    logic             add_ovf, sub_ovf, s2_ovf_d, s2_ill_d;
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        sum      = s1_a_q + s1_b_q;
        dif      = s1_a_q - s1_b_q;
        add_ovf  = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
        sub_ovf  = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (dif[WIDTH-1] != s1_a_q[WIDTH-1]);
        s2_ill_d = s1_op_q > OP_W'(3);
        s2_ovf_d = (s1_op_q == OP_W'(0)) ? add_ovf : (s1_op_q == OP_W'(1)) ? sub_ovf : 1'b0;
        raw      = s2_ill_d ? '0 :
                   (s1_op_q == OP_W'(0)) ? sum :
                   (s1_op_q == OP_W'(1)) ? dif :
                   (s1_op_q == OP_W'(2)) ? (s1_a_q & s1_b_q) : (s1_a_q ^ s1_b_q);
`ifdef ALU_SATURATE_EN
        // on overflow the true result carries operand A's sign
        s2_ans_d = s2_ovf_d ? {s1_a_q[WIDTH-1], {(WIDTH-1){~s1_a_q[WIDTH-1]}}} : raw;
`else
        s2_ans_d = raw;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_ans_q    <= '0;
            s2_ovf_q    <= 1'b0;
            s2_ill_q    <= 1'b0;
            s2_set_cc_q <= 1'b0;
            s2_zf_q     <= 1'b1;
            s2_sf_q     <= 1'b0;
            cc_zf_q     <= 1'b1;
            cc_sf_q     <= 1'b0;
            cc_of_q     <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q  <= in_valid;
                s1_a_q      <= in_a;
                s1_b_q      <= in_b;
                s1_op_q     <= in_op;
                s1_set_cc_q <= in_set_cc;
            end
            if (adv2) begin
                s2_valid_q  <= s1_valid_q;
                s2_ans_q    <= s2_ans_d;
                s2_ovf_q    <= s2_ovf_d;
                s2_ill_q    <= s2_ill_d;
                s2_set_cc_q <= s1_set_cc_q && !s2_ill_d;
                s2_zf_q     <= s2_ans_d == '0;
                s2_sf_q     <= s2_ans_d[WIDTH-1];
            end
            if (s2_valid_q && out_ready && s2_set_cc_q) begin
                cc_zf_q <= s2_zf_q;
                cc_sf_q <= s2_sf_q;
                cc_of_q <= s2_ovf_q;
            end
        end
    end
    assign in_ready     = adv1;
    assign out_valid    = s2_valid_q;
    assign out_ans      = s2_ans_q;
    assign out_overflow = s2_ovf_q;
    assign out_illegal  = s2_ill_q;
    assign cc_zf        = cc_zf_q;
    assign cc_sf        = cc_sf_q;
    assign cc_of        = cc_of_q;
endmodule

// File: tb/tb_alu_pipe_cc.sv
// tb_alu_pipe_cc: scoreboard bench for alu_pipe_cc (WIDTH=64); honours ALU_SATURATE_EN
module tb_alu_pipe_cc;
    localparam int W = 64;
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_set_cc = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [3:0]   in_op = '0;
    logic         in_ready, out_valid, out_overflow, out_illegal, cc_zf, cc_sf, cc_of;
    logic [W-1:0] out_ans;
    alu_pipe_cc #(.WIDTH(W), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_set_cc(in_set_cc), .out_valid(out_valid), .out_ready(out_ready),
        .out_ans(out_ans), .out_overflow(out_overflow), .out_illegal(out_illegal),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [W-1:0] ans;
        logic         ovf, ill, sc, zf, sf;
    } exp_t;
    exp_t         q[$];
    int           stamp[$];
    exp_t         e;
    int           cyc = 0, n_vec = 0, n_err = 0;
    logic [2:0]   exp_cc = 3'b100;
    logic         prev_stall = 1'b0, saw_stall = 1'b0;
    logic [W-1:0] prev_ans = '0;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask
    task automatic chk1(input string tag, input logic got, input logic want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input logic sc);
        exp_t r;
        logic [W:0] t;
        r = '0;
        t = '0;
        r.ill = op > 4'd3;
        if (op == 4'd0) t = {a[W-1], a} + {b[W-1], b};
        if (op == 4'd1) t = {a[W-1], a} - {b[W-1], b};
        if (op < 4'd2) begin
            r.ans = t[W-1:0];
            r.ovf = t[W] ^ t[W-1];
`ifdef ALU_SATURATE_EN
            if (r.ovf) r.ans = t[W] ? MINN : MAXP;
`endif
        end else if (op == 4'd2) r.ans = a & b;
        else if (op == 4'd3) r.ans = a ^ b;
        r.sc = sc && !r.ill;
        r.zf = r.ans == '0;
        r.sf = r.ans[W-1];
        return r;
    endfunction
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            stamp.delete();
            exp_cc = 3'b100;
            prev_stall = 1'b0;
        end else begin
            chk1("in_ready", in_ready, q.size() < 2 || out_ready);
            chk1("out_valid", out_valid, q.size() > 0 && (cyc - stamp[0]) >= 2);
            chk("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, exp_cc});
            if (prev_stall) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_ans", out_ans, prev_ans);
            end
            prev_stall = out_valid && !out_ready;
            prev_ans = out_ans;
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                void'(stamp.pop_front());
                chk("ans", out_ans, e.ans);
                chk1("ovf", out_overflow, e.ovf);
                chk1("illegal", out_illegal, e.ill);
                if (e.sc) exp_cc = {e.zf, e.sf, e.ovf};
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_op, in_set_cc));
                stamp.push_back(cyc);
            end
        end
    end
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input logic sc);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        in_set_cc = sc;
        @(negedge clk);
        for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
        chk1("accept", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    task automatic drain();
        for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
        chk1("drain", q.size() == 0, 1'b1);
        @(negedge clk);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_ans", out_ans, '0);
        chk1("rst_ovf", out_overflow, 1'b0);
        chk1("rst_illegal", out_illegal, 1'b0);
        chk1("rst_zf", cc_zf, 1'b1);
        chk1("rst_sf", cc_sf, 1'b0);
        chk1("rst_of", cc_of, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        step();
        send(MINN, 64'd1, 4'd1, 1'b1);
        drain();
        chk1("subov_zf", cc_zf, 1'b0);
`ifdef ALU_SATURATE_EN
        chk1("subov_sf", cc_sf, 1'b1);
`else
        chk1("subov_sf", cc_sf, 1'b0);
`endif
        chk1("subov_of", cc_of, 1'b1);
        step();
        send(MAXP, 64'd1, 4'd0, 1'b0);
        send(64'd69, 64'd420, 4'd1, 1'b1);
        drain();
        chk1("sub_neg_zf", cc_zf, 1'b0);
        chk1("sub_neg_sf", cc_sf, 1'b1);
        chk1("sub_neg_of", cc_of, 1'b0);
        step();
        send(64'h5A, 64'h5A, 4'd3, 1'b1);
        send(64'hF0, 64'h0F, 4'd2, 1'b0);
        drain();
        chk1("xor_zf", cc_zf, 1'b1);
        chk1("xor_sf", cc_sf, 1'b0);
        step();
        saw_stall = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(64'(i * 1000 + 7), 64'(i + 3), 4'(i % 4), 1'b1);
            begin
                repeat (3) step();
                out_ready = 1'b0;
                repeat (4) step();
                out_ready = 1'b1;
            end
        join
        drain();
        chk1("stall_seen", saw_stall, 1'b1);
        step();
        send(64'd1, 64'd2, 4'd7, 1'b1);
        drain();
        step();
        out_ready = 1'b0;
        send(64'd5, 64'd0, 4'd0, 1'b1);
        send(64'd6, 64'd0, 4'd0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_zf", cc_zf, 1'b1);
        chk1("midrst_sf", cc_sf, 1'b0);
        chk1("midrst_of", cc_of, 1'b0);
        repeat (4) step();
        send(64'd3, 64'd3, 4'd1, 1'b1);
        drain();
        chk1("post_zf", cc_zf, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
